video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised raster timing and test-pattern generator for the HDMI/DVI output path; next generation of the fixed 640x480 debug generator.
- Produces pData/pHSync/pVSync/pVDE toward the TMDS encoder for any resolution.
- Selectable test patterns with a movable marker pixel; exports frame, line and pixel counters for debug.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, HSync active level (0 = active-low)
- VS_POL, 0, VSync active level
- CW, 12, width of h/v counters and marker coordinates

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  1 = run timing; 0 = hold idle
- mode  in  2  pattern: 0 solid bg_color, 1 8 colour bars, 2 grid, 3 checkerboard
- marker_en  in  1  enable marker pixel
- marker_x  in  CW  marker column (active-area coordinate)
- marker_y  in  CW  marker line (active-area coordinate)
- marker_color  in  24  marker RGB
- bg_color  in  24  background RGB
- pData  out  24  pixel RGB
- pHSync  out  1  horizontal sync
- pVSync  out  1  vertical sync
- pVDE  out  1  data enable
- sof  out  1  one-cycle pulse with first active pixel of frame
- h_cnt  out  CW  current pixel counter
- v_cnt  out  CW  current line counter
- frame_cnt  out  16  completed-frame counter

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise (defaults 800 x 525 = 420000 clocks/frame).
- Counter layout: h_cnt runs 0..H_TOTAL-1; 0..H_ACTIVE-1 is active, followed by FP, SYNC, BP. v_cnt uses the same layout and increments when h_cnt wraps. v_cnt wraps to 0 at V_TOTAL-1 on the h wrap.
- Sync windows:
  - HSync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - VSync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. VSync is line-aligned and changes at h_cnt = 0.
- pVDE = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Latency: all video outputs are registered, so pixel (h,v) appears on pData/pVDE/pHSync/pVSync one clock after h_cnt/v_cnt show (h,v). h_cnt/v_cnt ports are the live counters.
- Frame-boundary sampling: mode, marker_en, marker_x, marker_y, marker_color and bg_color are sampled when h_cnt=0 and v_cnt=0. They stay constant for the rest of the frame, so changes never tear a frame.
- Patterns (using sampled values; pData=0 whenever pVDE=0):
  - mode 0: bg_color.
  - mode 1: 8 vertical bars, boundaries at h = k*H_ACTIVE/8 (constants computed at elaboration, no runtime divider). Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - mode 2: FFFFFF when h_cnt[4:0]==0 or v_cnt[4:0]==0, else bg_color.
  - mode 3: FFFFFF when h_cnt[5]^v_cnt[5], else bg_color.
  - Marker: if marker_en and (h_cnt,v_cnt) == (marker_x,marker_y), pData = marker_color, overriding the pattern. Off-screen coordinates produce no marker.
- sof: asserted on the same cycle pVDE first rises in a frame (pixel 0,0).
- frame_cnt: increments on the v_cnt wrap; 16-bit, wraps FFFF->0000.
- enable=0: next clock h_cnt=v_cnt=0 and outputs are idle (syncs inactive, pVDE=0, pData=0, sof=0). frame_cnt holds.
- enable rising: the frame starts at (0,0); the first pixel is output one clock later with sof.
- Reset: h_cnt=v_cnt=0, frame_cnt=0, pData=0, pVDE=0, sof=0, pHSync=~HS_POL, pVSync=~VS_POL. Sampled controls reset to mode 0, marker off, bg 000000. Reset is legal mid-frame.

Test Plan:
- Defaults, enable=1, run 2 frames -> pVDE high 640 clks/line on 480 lines per frame; sof period 420000 clks; frame_cnt=2.
- Default timing -> pHSync low exactly for h 656..751 (96 clks); pVSync low for lines 490..491 (1600 clks); sync polarity inverts when HS_POL=VS_POL=1.
- mode=1 -> pixels 0,79 = FFFFFF; 80 = FFFF00; 560..639 = 000000 on every active line.
- mode=3 with marker_en=1, marker=(100,50), marker_color=00FF00 -> exactly one 00FF00 pixel per frame at (100,50). Changing marker_x mid-frame takes effect only the next frame.
- Parameter set 1280x720 (FP 110, SYNC 40, BP 220, VFP 5, VSYNC 5, VBP 20) -> H_TOTAL 1650, V_TOTAL 750, sof period 1237500.
- enable dropped at line 200, then raised; and rstn asserted mid-line -> outputs idle within 1 clk; restart begins at (0,0) with sof; frame_cnt unchanged by enable, cleared by rstn.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Parametrised raster timing and test-pattern generator for the HDMI/DVI
// output path. Counters run free while enable is high; all video outputs are
// registered one clock behind the live h_cnt/v_cnt.
//
// Ports:
//   clk, rstn          pixel clock, asynchronous active-low reset
//   enable             1 = run timing, 0 = hold counters at (0,0) with idle outputs
//   mode               0 solid bg_color, 1 colour bars, 2 grid, 3 checkerboard
//   marker_*           single marker pixel (active-area coordinates)
//   bg_color           background RGB used by patterns 0, 2, 3
//   pData/pHSync/pVSync/pVDE   video toward the TMDS encoder
//   sof                pulse with the first active pixel of a frame
//   h_cnt/v_cnt        live pixel/line counters
//   frame_cnt          completed-frame counter (wraps)
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic          marker_en,
  input  logic [CW-1:0] marker_x,
  input  logic [CW-1:0] marker_y,
  input  logic [23:0]   marker_color,
  input  logic [23:0]   bg_color,
  output logic [23:0]   pData,
  output logic          pHSync,
  output logic          pVSync,
  output logic          pVDE,
  output logic          sof,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Colour-bar boundaries, resolved at elaboration so no divider is built.
  localparam logic [CW-1:0] BAR_1 = CW'(1 * H_ACTIVE / 8);
  localparam logic [CW-1:0] BAR_2 = CW'(2 * H_ACTIVE / 8);
  localparam logic [CW-1:0] BAR_3 = CW'(3 * H_ACTIVE / 8);
  localparam logic [CW-1:0] BAR_4 = CW'(4 * H_ACTIVE / 8);
  localparam logic [CW-1:0] BAR_5 = CW'(5 * H_ACTIVE / 8);
  localparam logic [CW-1:0] BAR_6 = CW'(6 * H_ACTIVE / 8);
  localparam logic [CW-1:0] BAR_7 = CW'(7 * H_ACTIVE / 8);

  localparam logic [23:0] WHITE = 24'hFFFFFF;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  logic [CW-1:0] h_cnt_r, v_cnt_r;
  logic [15:0]   frame_cnt_r;
  logic [1:0]    mode_r;
  logic          marker_en_r;
  logic [CW-1:0] marker_x_r, marker_y_r;
  logic [23:0]   marker_color_r, bg_color_r;
  logic [23:0]   pdata_r;
  logic          hsync_r, vsync_r, vde_r, sof_r;

  logic          frame_start_s, de_s, hs_act_s, vs_act_s, marker_hit_s;
  logic [1:0]    eff_mode_s;
  logic          eff_marker_en_s;
  logic [CW-1:0] eff_marker_x_s, eff_marker_y_s;
  logic [23:0]   eff_marker_color_s, eff_bg_s;
  logic [2:0]    bar_idx_s;
  logic [23:0]   pattern_s, pixel_s;

  assign frame_start_s = (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);
  assign de_s          = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
  assign hs_act_s      = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
  assign vs_act_s      = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);

  // Pixel/line/frame counters; disabled timing parks at the frame origin.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_r     <= CNT_ZERO;
      v_cnt_r     <= CNT_ZERO;
      frame_cnt_r <= 16'd0;
    end else if (!enable) begin
      h_cnt_r <= CNT_ZERO;
      v_cnt_r <= CNT_ZERO;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= CNT_ZERO;
      if (v_cnt_r == V_LAST) begin
        v_cnt_r     <= CNT_ZERO;
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        v_cnt_r <= v_cnt_r + CW'(1);
      end
    end else begin
      h_cnt_r <= h_cnt_r + CW'(1);
    end
  end

  // Control snapshot taken at the frame origin so a frame never tears.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_r         <= 2'd0;
      marker_en_r    <= 1'b0;
      marker_x_r     <= CNT_ZERO;
      marker_y_r     <= CNT_ZERO;
      marker_color_r <= 24'h000000;
      bg_color_r     <= 24'h000000;
    end else if (frame_start_s) begin
      mode_r         <= mode;
      marker_en_r    <= marker_en;
      marker_x_r     <= marker_x;
      marker_y_r     <= marker_y;
      marker_color_r <= marker_color;
      bg_color_r     <= bg_color;
    end
  end

  // Pixel (0,0) is rendered in the sampling cycle itself, so it uses the live inputs.
  always_comb begin
    eff_mode_s         = mode_r;
    eff_marker_en_s    = marker_en_r;
    eff_marker_x_s     = marker_x_r;
    eff_marker_y_s     = marker_y_r;
    eff_marker_color_s = marker_color_r;
    eff_bg_s           = bg_color_r;
    if (frame_start_s) begin
      eff_mode_s         = mode;
      eff_marker_en_s    = marker_en;
      eff_marker_x_s     = marker_x;
      eff_marker_y_s     = marker_y;
      eff_marker_color_s = marker_color;
      eff_bg_s           = bg_color;
    end else begin
      eff_mode_s = mode_r;
    end
  end

  // Colour-bar index from the elaboration-time boundaries.
  always_comb begin
    bar_idx_s = 3'd7;
    if (h_cnt_r < BAR_1) begin
      bar_idx_s = 3'd0;
    end else if (h_cnt_r < BAR_2) begin
      bar_idx_s = 3'd1;
    end else if (h_cnt_r < BAR_3) begin
      bar_idx_s = 3'd2;
    end else if (h_cnt_r < BAR_4) begin
      bar_idx_s = 3'd3;
    end else if (h_cnt_r < BAR_5) begin
      bar_idx_s = 3'd4;
    end else if (h_cnt_r < BAR_6) begin
      bar_idx_s = 3'd5;
    end else if (h_cnt_r < BAR_7) begin
      bar_idx_s = 3'd6;
    end else begin
      bar_idx_s = 3'd7;
    end
  end

  // Pattern selection, marker override and blanking.
  always_comb begin
    pattern_s    = eff_bg_s;
    pixel_s      = 24'h000000;
    marker_hit_s = eff_marker_en_s && (h_cnt_r == eff_marker_x_s) && (v_cnt_r == eff_marker_y_s);
    case (eff_mode_s)
      2'd0: pattern_s = eff_bg_s;
      2'd1: pattern_s = bar_color(bar_idx_s);
      2'd2: pattern_s = ((h_cnt_r[4:0] == 5'd0) || (v_cnt_r[4:0] == 5'd0)) ? WHITE : eff_bg_s;
      2'd3: pattern_s = (h_cnt_r[5] ^ v_cnt_r[5]) ? WHITE : eff_bg_s;
      default: pattern_s = eff_bg_s;
    endcase
    if (!de_s) begin
      pixel_s = 24'h000000;
    end else if (marker_hit_s) begin
      pixel_s = eff_marker_color_s;
    end else begin
      pixel_s = pattern_s;
    end
  end

  // Registered video outputs, one clock behind the live counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pdata_r <= 24'h000000;
      hsync_r <= ~HS_POL;
      vsync_r <= ~VS_POL;
      vde_r   <= 1'b0;
      sof_r   <= 1'b0;
    end else if (!enable) begin
      pdata_r <= 24'h000000;
      hsync_r <= ~HS_POL;
      vsync_r <= ~VS_POL;
      vde_r   <= 1'b0;
      sof_r   <= 1'b0;
    end else begin
      pdata_r <= pixel_s;
      hsync_r <= hs_act_s ? HS_POL : ~HS_POL;
      vsync_r <= vs_act_s ? VS_POL : ~VS_POL;
      vde_r   <= de_s;
      sof_r   <= frame_start_s;
    end
  end

  assign pData     = pdata_r;
  assign pHSync    = hsync_r;
  assign pVSync    = vsync_r;
  assign pVDE      = vde_r;
  assign sof       = sof_r;
  assign h_cnt     = h_cnt_r;
  assign v_cnt     = v_cnt_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a reduced raster
// (80 x 40 clocks per frame) so several frames fit in a short run.
module tb_video_timing_gen;

  localparam int HA = 64, HF = 4, HS = 6, HB = 6;
  localparam int VA = 34, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 80
  localparam int VT = VA + VF + VS + VB;   // 40
  localparam int FR = HT * VT;             // 3200

  logic        clk = 1'b0;
  logic        rstn, enable, marker_en;
  logic [1:0]  mode;
  logic [11:0] marker_x, marker_y;
  logic [23:0] marker_color, bg_color;
  logic [23:0] pData;
  logic        pHSync, pVSync, pVDE, sof;
  logic [11:0] h_cnt, v_cnt;
  logic [15:0] frame_cnt;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .mode(mode),
    .marker_en(marker_en), .marker_x(marker_x), .marker_y(marker_y),
    .marker_color(marker_color), .bg_color(bg_color),
    .pData(pData), .pHSync(pHSync), .pVSync(pVSync), .pVDE(pVDE), .sof(sof),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic        hs, vs, de, sof;
    logic [11:0] h, v;
    logic [15:0] fc;
  } obs_t;

  obs_t exp_q[$];
  obs_t act_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  int          mh, mv;
  logic [15:0] mf;
  logic [1:0]  s_mode;
  logic        s_men;
  int          s_mx, s_my;
  logic [23:0] s_mc, s_bg;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic model_reset();
    mh = 0; mv = 0; mf = 16'd0;
    s_mode = 2'd0; s_men = 1'b0; s_mx = 0; s_my = 0; s_mc = 24'h0; s_bg = 24'h0;
  endtask

  // Push the expected observation for the next clock, advance, capture actual.
  task automatic tick();
    obs_t e;
    e = '0;
    if (mh == 0 && mv == 0) begin
      s_mode = mode; s_men = marker_en; s_mx = int'(marker_x); s_my = int'(marker_y);
      s_mc = marker_color; s_bg = bg_color;
    end
    if (enable) begin
      e.hs  = (mh >= HA + HF && mh < HA + HF + HS) ? 1'b0 : 1'b1;
      e.vs  = (mv >= VA + VF && mv < VA + VF + VS) ? 1'b0 : 1'b1;
      e.de  = (mh < HA) && (mv < VA);
      e.sof = (mh == 0) && (mv == 0);
      if (e.de) begin
        case (s_mode)
          2'd0: e.d = s_bg;
          2'd1: e.d = bars[(mh * 8) / HA];
          2'd2: e.d = ((mh % 32 == 0) || (mv % 32 == 0)) ? 24'hFFFFFF : s_bg;
          default: e.d = (((mh / 32) % 2) != ((mv / 32) % 2)) ? 24'hFFFFFF : s_bg;
        endcase
        if (s_men && mh == s_mx && mv == s_my) e.d = s_mc;
      end
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0; mv = mv + 1;
        if (mv == VT) begin mv = 0; mf = mf + 16'd1; end
      end
    end else begin
      e.hs = 1'b1; e.vs = 1'b1; mh = 0; mv = 0;
    end
    e.h = mh[11:0]; e.v = mv[11:0]; e.fc = mf;
    exp_q.push_back(e);
    @(posedge clk); #1;
    act_q.push_back({pData, pHSync, pVSync, pVDE, sof, h_cnt, v_cnt, frame_cnt});
  endtask

  task automatic test_reset();
    obs_t r, a;
    r = '0; r.hs = 1'b1; r.vs = 1'b1;
    rstn = 1'b0; enable = 1'b0; mode = 2'd0; marker_en = 1'b0;
    marker_x = 12'd0; marker_y = 12'd0; marker_color = 24'h0; bg_color = 24'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    a = {pData, pHSync, pVSync, pVDE, sof, h_cnt, v_cnt, frame_cnt};
    n_checks++;
    if (a !== r) $display("FAIL reset_state got %h expected %h", a, r); else n_pass++;
    enable = 1'b1;
    @(posedge clk); #1;
    a = {pData, pHSync, pVSync, pVDE, sof, h_cnt, v_cnt, frame_cnt};
    n_checks++;
    if (a !== r) $display("FAIL reset_hold got %h expected %h", a, r); else n_pass++;
    @(negedge clk);
    enable = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_two_frames();
    obs_t e, a;
    int de_n, hs_n, vs_n, sof_n, last_sof, sof_per;
    de_n = 0; hs_n = 0; vs_n = 0; sof_n = 0; last_sof = -1; sof_per = 0;
    enable = 1'b1; mode = 2'd0; bg_color = 24'h123456;
    for (int k = 0; k < 2 * FR; k++) tick();
    for (int k = 0; k < 2 * FR; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) $display("FAIL two_frames cyc %0d got %h expected %h", k, a, e); else n_pass++;
      de_n += int'(a.de); hs_n += int'(!a.hs); vs_n += int'(!a.vs);
      if (a.sof) begin
        if (last_sof >= 0) sof_per = k - last_sof;
        last_sof = k; sof_n++;
      end
    end
    n_checks++;
    if (de_n !== 2 * HA * VA) $display("FAIL de_count got %0d expected %0d", de_n, 2 * HA * VA); else n_pass++;
    n_checks++;
    if (hs_n !== 2 * VT * HS) $display("FAIL hsync_count got %0d expected %0d", hs_n, 2 * VT * HS); else n_pass++;
    n_checks++;
    if (vs_n !== 2 * VS * HT) $display("FAIL vsync_count got %0d expected %0d", vs_n, 2 * VS * HT); else n_pass++;
    n_checks++;
    if (sof_n !== 2 || sof_per !== FR) $display("FAIL sof_period got n=%0d per=%0d expected n=2 per=%0d", sof_n, sof_per, FR); else n_pass++;
    n_checks++;
    if (frame_cnt !== 16'd2) $display("FAIL frame_cnt2 got %0d expected 2", frame_cnt); else n_pass++;
  endtask

  task automatic test_bars();
    obs_t e, a;
    int px;
    logic [23:0] want;
    mode = 2'd1;
    for (int k = 0; k < FR; k++) tick();
    for (int k = 0; k < FR; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) $display("FAIL bars cyc %0d got %h expected %h", k, a, e); else n_pass++;
      px = k % HT;
      if (k / HT == 3 && (px == 0 || px == 7 || px == 8 || px == 56 || px == 63)) begin
        want = (px < 8) ? 24'hFFFFFF : (px == 8) ? 24'hFFFF00 : 24'h000000;
        n_checks++;
        if (a.d !== want) $display("FAIL bar_px%0d got %h expected %h", px, a.d, want); else n_pass++;
      end
    end
  endtask

  task automatic test_grid();
    obs_t e, a;
    int white;
    white = 0;
    mode = 2'd2; bg_color = 24'h202020;
    for (int k = 0; k < FR; k++) tick();
    for (int k = 0; k < FR; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) $display("FAIL grid cyc %0d got %h expected %h", k, a, e); else n_pass++;
      white += int'(a.d == 24'hFFFFFF);
    end
    n_checks++;
    if (white !== 192) $display("FAIL grid_white got %0d expected 192", white); else n_pass++;
  endtask

  task automatic test_marker();
    obs_t e, a;
    int green [3];
    int gpos [3];
    int white0;
    green = '{0, 0, 0}; gpos = '{-1, -1, -1}; white0 = 0;
    mode = 2'd3; bg_color = 24'h000000; marker_en = 1'b1;
    marker_x = 12'd10; marker_y = 12'd20; marker_color = 24'h00FF00;
    for (int k = 0; k < 3 * FR; k++) begin
      if (k == 1000) marker_x = 12'd30;
      if (k == 2 * FR) marker_x = 12'd70;
      tick();
    end
    for (int k = 0; k < 3 * FR; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) $display("FAIL marker cyc %0d got %h expected %h", k, a, e); else n_pass++;
      if (a.d == 24'h00FF00) begin green[k / FR]++; gpos[k / FR] = k % FR; end
      if (k < FR && a.d == 24'hFFFFFF) white0++;
    end
    n_checks++;
    if (green[0] !== 1 || gpos[0] !== 20 * HT + 10) $display("FAIL marker_f0 got n=%0d pos=%0d expected n=1 pos=%0d", green[0], gpos[0], 20 * HT + 10); else n_pass++;
    n_checks++;
    if (green[1] !== 1 || gpos[1] !== 20 * HT + 30) $display("FAIL marker_f1 got n=%0d pos=%0d expected n=1 pos=%0d", green[1], gpos[1], 20 * HT + 30); else n_pass++;
    n_checks++;
    if (green[2] !== 0) $display("FAIL marker_offscreen got %0d expected 0", green[2]); else n_pass++;
    n_checks++;
    if (white0 !== 1088) $display("FAIL checker_white got %0d expected 1088", white0); else n_pass++;
    marker_en = 1'b0;
  endtask

  task automatic test_enable();
    obs_t e, a;
    mode = 2'd0; bg_color = 24'hA5A5A5;
    for (int k = 0; k < 1600 + 5 + FR; k++) begin
      if (k == 1600) enable = 1'b0;
      if (k == 1605) enable = 1'b1;
      tick();
    end
    for (int k = 0; k < 1605 + FR; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) $display("FAIL enable cyc %0d got %h expected %h", k, a, e); else n_pass++;
      if (k == 1600) begin
        n_checks++;
        if (a.de !== 1'b0 || a.d !== 24'h0 || a.h !== 12'd0) $display("FAIL idle_1clk got de=%b d=%h h=%0d expected 0", a.de, a.d, a.h); else n_pass++;
      end
      if (k == 1604) begin
        n_checks++;
        if (a.fc !== 16'd7) $display("FAIL fc_hold got %0d expected 7", a.fc); else n_pass++;
      end
      if (k == 1605) begin
        n_checks++;
        if (a.sof !== 1'b1 || a.d !== 24'hA5A5A5) $display("FAIL restart_sof got sof=%b d=%h expected 1 a5a5a5", a.sof, a.d); else n_pass++;
      end
    end
    n_checks++;
    if (frame_cnt !== 16'd8) $display("FAIL fc_after_enable got %0d expected 8", frame_cnt); else n_pass++;
  endtask

  task automatic test_reset_midline();
    obs_t e, a, r;
    r = '0; r.hs = 1'b1; r.vs = 1'b1;
    for (int k = 0; k < 130; k++) tick();
    for (int k = 0; k < 130; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) $display("FAIL pre_reset cyc %0d got %h expected %h", k, a, e); else n_pass++;
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    a = {pData, pHSync, pVSync, pVDE, sof, h_cnt, v_cnt, frame_cnt};
    n_checks++;
    if (a !== r) $display("FAIL async_reset got %h expected %h", a, r); else n_pass++;
    @(posedge clk); #1;
    a = {pData, pHSync, pVSync, pVDE, sof, h_cnt, v_cnt, frame_cnt};
    n_checks++;
    if (a !== r) $display("FAIL reset_held got %h expected %h", a, r); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int k = 0; k < 200; k++) tick();
    for (int k = 0; k < 200; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) $display("FAIL post_reset cyc %0d got %h expected %h", k, a, e); else n_pass++;
      if (k == 0) begin
        n_checks++;
        if (a.sof !== 1'b1 || a.fc !== 16'd0) $display("FAIL reset_restart got sof=%b fc=%0d expected 1 0", a.sof, a.fc); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_bars();
    test_grid();
    test_marker();
    test_enable();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
